// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative RV32M multiply/divide unit. It sits upstream of the register
//   file write port: it takes the rs1/rs2 read values plus funct3 and returns
//   a 32-bit result with a one-cycle resultValid pulse. busy stalls the core
//   while an operation is in flight.
//
//   Multiply: shift/add over a 64-bit accumulator. The multiplicand is sign-
//   or zero-extended to 64 bits. A signed multiplier's bit 31 carries weight
//   -2^31, so that partial product is subtracted instead of added.
//   Divide: restoring division on operand magnitudes, with the quotient and
//   remainder signs applied in the DONE cycle. Divide-by-zero and signed
//   overflow are resolved when the operation is accepted.
//
//   Configuration macro: FAST_MUL_EN
//     defined   -> multiplies use one combinational 33x33 signed multiply and
//                  go straight from IDLE to DONE. The divide path is unchanged.
//     undefined -> all multiplies are iterative and no multiplier is inferred.
//
// Parameters
//   STEPS_PER_CYCLE  shift/add(sub) steps per clock: 1, 2 or 4 (ITER = 32/STEPS)
//
// Ports
//   clock        in   1   core clock, all state on posedge
//   reset        in   1   synchronous, active-high
//   start        in   1   request, sampled only while busy == 0
//   funct3       in   3   0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   rs1          in  32   operand A (dividend / multiplicand)
//   rs2          in  32   operand B (divisor / multiplier)
//   busy         out  1   operation in progress
//   resultValid  out  1   one-cycle pulse, result valid
//   result       out 32   RV32M result, held until the next completion
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        resultValid,
  output logic [31:0] result
);

  localparam int         ITER     = 32 / STEPS_PER_CYCLE;
  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  // Control state
  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;

  // Datapath state
  logic [2:0]  op_q, op_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        special_q, special_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  // Step variables carried through the unrolled per-cycle loop
  logic [63:0] acc_v, mcand_v;
  logic [31:0] mplier_v, quo_v;
  logic [32:0] rem_v;

  // Decode of the incoming request, used only in the acceptance cycle
  logic        div_signed, div_by_zero, div_ovf, special;
  logic [31:0] special_val;
  logic        rs1_neg, rs2_neg;
  logic [31:0] rs1_mag, rs2_mag;
  logic        mul_a_signed;
  logic [63:0] mcand_init;

  assign div_signed   = ~funct3[0];
  assign div_by_zero  = (rs2 == 32'h0);
  assign div_ovf      = div_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign special      = funct3[2] && (div_by_zero || div_ovf);
  // funct3[1] separates REM/REMU from DIV/DIVU.
  assign special_val  = div_by_zero ? (funct3[1] ? rs1 : 32'hFFFF_FFFF)
                                    : (funct3[1] ? 32'h0 : 32'h8000_0000);
  assign rs1_neg      = div_signed & rs1[31];
  assign rs2_neg      = div_signed & rs2[31];
  assign rs1_mag      = rs1_neg ? -rs1 : rs1;
  assign rs2_mag      = rs2_neg ? -rs2 : rs2;
  // rs1 is signed for MUL, MULH and MULHSU, and unsigned only for MULHU.
  assign mul_a_signed = (funct3[1:0] != 2'b11);
  assign mcand_init   = {{32{mul_a_signed & rs1[31]}}, rs1};

`ifdef FAST_MUL_EN
  logic signed [32:0] fast_a, fast_b;
  logic signed [65:0] fast_prod;
  assign fast_a    = {mul_a_signed & rs1[31], rs1};
  assign fast_b    = {~funct3[1] & rs2[31], rs2};
  assign fast_prod = fast_a * fast_b;
`endif

  // NOTE: every variable gets its hold/default value before the case so that
  // no path leaves it unassigned. A path that skipped a variable would infer a latch.
  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    special_d = special_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    acc_v     = acc_q;
    mcand_v   = mcand_q;
    mplier_v  = mplier_q;
    rem_v     = rem_q;
    quo_v     = quo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = funct3;
          cnt_d     = '0;
          special_d = 1'b0;
          if (funct3[2]) begin
            if (special) begin
              // The special-case answer waits in the accumulator for DONE.
              special_d = 1'b1;
              acc_d     = {32'h0, special_val};
              state_d   = S_DONE;
            end else begin
              rem_d     = '0;
              quo_d     = rs1_mag;
              divisor_d = rs2_mag;
              neg_quo_d = rs1_neg ^ rs2_neg;
              neg_rem_d = rs1_neg;
              state_d   = S_DIV;
            end
          end else begin
`ifdef FAST_MUL_EN
            acc_d   = fast_prod[63:0];
            state_d = S_DONE;
`else
            acc_d    = '0;
            mcand_d  = mcand_init;
            mplier_d = rs2;
            state_d  = S_MUL;
`endif
          end
        end
      end

      S_MUL: begin
        for (int k = 0; k < STEPS_PER_CYCLE; k++) begin
          if (mplier_v[0]) begin
            // Bit 31 of a signed multiplier (MUL/MULH) has negative weight.
            if (~op_q[1] && (cnt_q == LAST_CNT) && (k == STEPS_PER_CYCLE - 1))
              acc_v = acc_v - mcand_v;
            else
              acc_v = acc_v + mcand_v;
          end
          mcand_v  = mcand_v << 1;
          mplier_v = mplier_v >> 1;
        end
        acc_d    = acc_v;
        mcand_d  = mcand_v;
        mplier_d = mplier_v;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == LAST_CNT) state_d = S_DONE;
      end

      S_DIV: begin
        for (int k = 0; k < STEPS_PER_CYCLE; k++) begin
          // The dividend bits shift out of quo while quotient bits shift in.
          rem_v = {rem_v[31:0], quo_v[31]};
          quo_v = quo_v << 1;
          if (rem_v >= {1'b0, divisor_q}) begin
            rem_v    = rem_v - {1'b0, divisor_q};
            quo_v[0] = 1'b1;
          end
        end
        rem_d = rem_v;
        quo_d = quo_v;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_CNT) state_d = S_DONE;
      end

      S_DONE: begin
        valid_d = 1'b1;
        state_d = S_IDLE;
        if (special_q)
          result_d = acc_q[31:0];
        else if (op_q[2])
          result_d = op_q[1] ? (neg_rem_q ? -rem_q[31:0] : rem_q[31:0])
                             : (neg_quo_q ? -quo_q : quo_q);
        else
          result_d = (op_q[1:0] == 2'b00) ? acc_q[31:0] : acc_q[63:32];
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever order the statements run in.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  // NOTE: datapath registers have no reset. They are always loaded at
  // acceptance before they are read, so a reset would only add fan-out.
  always_ff @(posedge clock) begin
    op_q      <= op_d;
    cnt_q     <= cnt_d;
    special_q <= special_d;
    acc_q     <= acc_d;
    mcand_q   <= mcand_d;
    mplier_q  <= mplier_d;
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    divisor_q <= divisor_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

  assign busy        = (state_q != S_IDLE);
  assign resultValid = valid_q;
  assign result      = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit. Expected results come from a plain
//   arithmetic RV32M model (64-bit products, native signed/unsigned division).
//   Expected latencies come from the operation class: iterative operations
//   pulse resultValid ITER+1 edges after acceptance, and special cases or fast
//   multiplies pulse one edge after acceptance.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        resultValid;
  logic [31:0] result;

  int n_checks = 0;
  int n_fails  = 0;

  localparam int ITER_LAT = 33;

  mul_div_unit #(.STEPS_PER_CYCLE(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .busy       (busy),
    .resultValid(resultValid),
    .result     (result)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dirs [13] = '{
    '{3'd0, 32'd7,          32'd6,          32'd42},
    '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
    '{3'd5, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF},
    '{3'd7, 32'hFFFF_FFFF,  32'd16,         32'h0000_000F},
    '{3'd4, 32'd1234,       32'd0,          32'hFFFF_FFFF},
    '{3'd7, 32'd5,          32'd0,          32'd5},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0},
    '{3'd5, 32'd100,        32'd7,          32'd14}
  };

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib, q;
    logic [31:0] r;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0)   r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin q = ia / ib; r = q; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0)   r = a;
        else if (ovf) r = 32'h0;
        else begin q = ia % ib; r = q; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Edges from acceptance until the edge after which resultValid is high.
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2]) begin
      if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return ITER_LAT;
    end
`ifdef FAST_MUL_EN
    return 1;
`else
    return ITER_LAT;
`endif
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation, scramble the inputs and poke start while busy, then
  // check the latency, the result, the single-cycle pulse and the held result.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input string tag);
    int lat;
    int c;
    lat = ref_latency(f, a, b);
    check({tag, " idle_before"}, 32'(busy), 32'd0);
    start  = 1'b1;
    funct3 = f;
    rs1    = a;
    rs2    = b;
    step();
    c = 0;
    while (!resultValid && c < 200) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      start  = (c < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      funct3 = 3'($urandom);
      rs1    = $urandom;
      rs2    = $urandom;
      step();
      c++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(c), 32'(lat));
    check({tag, " result"}, result, exp_r);
    check({tag, " busy_in_valid"}, 32'(busy), 32'd0);
    step();
    check({tag, " pulse_width"}, 32'(resultValid), 32'd0);
    check({tag, " held"}, result, exp_r);
  endtask

  initial begin
    int          pulses;
    int          acc_e, val_e, next_acc;
    logic [31:0] exp_b;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'd0;
    rs1    = 32'h0;
    rs2    = 32'h0;
    repeat (3) step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(resultValid), 32'd0);
    check("reset result", result, 32'h0);
    reset = 1'b0;
    step();
    check("post_reset busy", 32'(busy), 32'd0);

    foreach (dirs[i])
      run_op(dirs[i].f, dirs[i].a, dirs[i].b, dirs[i].exp, $sformatf("directed%0d", i));

    // Abort a divide ten cycles in; the previous result (14) must clear.
    start  = 1'b1;
    funct3 = 3'd4;
    rs1    = 32'd1000;
    rs2    = 32'd7;
    step();
    start = 1'b0;
    repeat (9) step();
    check("midop busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(resultValid), 32'd0);
    check("abort result", result, 32'h0);
    pulses = 0;
    repeat (40) begin
      step();
      if (resultValid) pulses++;
    end
    check("abort no_pulse", 32'(pulses), 32'd0);
    run_op(3'd4, 32'd1000, 32'd7, 32'd142, "div_after_reset");

    repeat (40) begin
      rf = 3'($urandom);
      ra = rand_operand();
      rb = rand_operand();
      run_op(rf, ra, rb, ref_result(rf, ra, rb), "random");
    end

    // start held high with operands changing every cycle: the model decides
    // which edges accept, from its own latency rule.
    acc_e    = -1000;
    val_e    = -1000;
    next_acc = 0;
    exp_b    = '0;
    for (int k = 0; k < 300; k++) begin
      if (k < 250) begin
        start  = 1'b1;
        funct3 = 3'($urandom);
        rs1    = rand_operand();
        rs2    = rand_operand();
        if (k == next_acc) begin
          exp_b    = ref_result(funct3, rs1, rs2);
          acc_e    = k;
          val_e    = k + ref_latency(funct3, rs1, rs2);
          next_acc = val_e + 1;
        end
      end else begin
        start = 1'b0;
      end
      step();
      check("b2b valid", 32'(resultValid), 32'(k == val_e));
      check("b2b busy", 32'(busy), 32'(k >= acc_e && k < val_e));
      if (k == val_e) check("b2b result", result, exp_b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
